// File: rtl/mips_pkg.sv
// Shared encodings for the MEM-stage data-memory port and the debug dump sequencer.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } dump_state_e;

    typedef enum logic [1:0] {
        RW_NONE    = 2'b00,
        RW_WRITE   = 2'b01,
        RW_READ    = 2'b10,
        RW_ILLEGAL = 2'b11
    } mem_rw_e;

    localparam logic [1:0] LEN_WORD = 2'b00;

    // The illegal request code is never allowed onto the memory port.
    function automatic logic [1:0] legal_rw(input logic [1:0] rw);
        return (rw == RW_ILLEGAL) ? RW_NONE : rw;
    endfunction

endpackage

// File: rtl/mem_debug_arbiter_if.sv
// Bus bundle around the arbiter: MEM-stage request, dump command, data-memory port, debug stream.
interface mem_debug_arbiter_if #(
    parameter int CNT_W = 16
) ();
    logic [1:0]       pipe_rw;
    logic [31:0]      pipe_addr;
    logic [31:0]      pipe_wdata;
    logic [1:0]       pipe_len;

    logic             dump_start;
    logic [31:0]      dump_base;
    logic [CNT_W-1:0] dump_count;

    logic [1:0]       mem_rw;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [1:0]       mem_len;
    logic [31:0]      mem_rdata;

    logic             dbg_valid;
    logic [31:0]      dbg_data;
    logic             dbg_ready;

    // master: the arbiter itself; slave: pipeline, memory and debug unit around it.
    modport master (
        input  pipe_rw, pipe_addr, pipe_wdata, pipe_len,
        input  dump_start, dump_base, dump_count,
        input  mem_rdata, dbg_ready,
        output mem_rw, mem_addr, mem_wdata, mem_len,
        output dbg_valid, dbg_data
    );

    modport slave (
        output pipe_rw, pipe_addr, pipe_wdata, pipe_len,
        output dump_start, dump_base, dump_count,
        output mem_rdata, dbg_ready,
        input  mem_rw, mem_addr, mem_wdata, mem_len,
        input  dbg_valid, dbg_data
    );
endinterface

// File: rtl/dump_addr_gen.sv
// Dump address generator: latches base/count, walks a word index, flags the final word.
module dump_addr_gen #(
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             incr,
    input  logic [31:0]      base_in,
    input  logic [CNT_W-1:0] count_in,
    output logic [31:0]      addr,
    output logic             last
);
    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    logic [31:0]      base_q,  base_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] index_q, index_d;

    always_comb begin
        base_d  = base_q;
        count_d = count_q;
        index_d = index_q;
        if (load) begin
            base_d  = base_in;
            count_d = count_in;
            index_d = '0;
        end else if (incr) begin
            index_d = index_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            count_q <= '0;
            index_q <= '0;
        end else begin
            base_q  <= base_d;
            count_q <= count_d;
            index_q <= index_d;
        end
    end

    // 32-bit arithmetic: a dump running past the top of memory wraps to address 0.
    assign addr = base_q + (32'(index_q) * STEP);
    assign last = (index_q == (count_q - CNT_W'(1)));

endmodule

// File: rtl/mem_debug_arbiter.sv
// Shares the MEM-stage data-memory port between the pipeline and a debug memory dump.
module mem_debug_arbiter
    import mips_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_debug_arbiter_if.master bus,
    output logic                stall,
    output logic                dump_busy,
    output logic                dump_done,
    output logic                err_conflict
);
    dump_state_e state_q, state_d;
    logic [31:0] dbg_data_q, dbg_data_d;
    logic        err_conflict_q, err_conflict_d;

    logic        gen_load;
    logic        gen_incr;
    logic        gen_last;
    logic [31:0] gen_addr;
    logic        pipe_req;

    dump_addr_gen #(
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (gen_load),
        .incr     (gen_incr),
        .base_in  (bus.dump_base),
        .count_in (bus.dump_count),
        .addr     (gen_addr),
        .last     (gen_last)
    );

    assign pipe_req = (bus.pipe_rw != RW_NONE);

    always_comb begin
        state_d        = state_q;
        dbg_data_d     = dbg_data_q;
        err_conflict_d = err_conflict_q;
        gen_load       = 1'b0;
        gen_incr       = 1'b0;
        bus.mem_rw     = RW_NONE;
        bus.mem_addr   = bus.pipe_addr;
        bus.mem_wdata  = bus.pipe_wdata;
        bus.mem_len    = bus.pipe_len;

        unique case (state_q)
            ST_IDLE: begin
                bus.mem_rw = legal_rw(bus.pipe_rw);
                if (bus.dump_start) begin
                    if (bus.dump_count != '0) begin
                        gen_load = 1'b1;
                        state_d  = ST_DRAIN;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            // The pipeline is already frozen, but the access sitting in MEM still completes.
            ST_DRAIN: begin
                bus.mem_rw = legal_rw(bus.pipe_rw);
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.mem_rw    = RW_READ;
                bus.mem_addr  = gen_addr;
                bus.mem_wdata = '0;
                bus.mem_len   = LEN_WORD;
                if (pipe_req) err_conflict_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                dbg_data_d = bus.mem_rdata;
                if (pipe_req) err_conflict_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (pipe_req) err_conflict_d = 1'b1;
                if (bus.dbg_ready) begin
                    if (gen_last) begin
                        state_d = ST_DONE;
                    end else begin
                        gen_incr = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            dbg_data_q     <= '0;
            err_conflict_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dbg_data_q     <= dbg_data_d;
            err_conflict_q <= err_conflict_d;
        end
    end

    // Status decodes straight off the state register so reset takes effect immediately.
    assign bus.dbg_valid = (state_q == ST_SEND);
    assign bus.dbg_data  = dbg_data_q;
    assign stall         = (state_q == ST_DRAIN) || (state_q == ST_ISSUE) ||
                           (state_q == ST_WAIT)  || (state_q == ST_SEND);
    assign dump_busy     = (state_q != ST_IDLE);
    assign dump_done     = (state_q == ST_DONE);
    assign err_conflict  = err_conflict_q;

endmodule

// File: tb/tb_mem_debug_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed and random stimulus.
module tb_mem_debug_arbiter;
    import mips_pkg::*;

    localparam int CNT_W     = 16;
    localparam int ADDR_STEP = 4;

    logic clk = 1'b0;
    logic rst;
    logic stall, dump_busy, dump_done, err_conflict;

    mem_debug_arbiter_if #(.CNT_W(CNT_W)) bus ();

    mem_debug_arbiter #(
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall        (stall),
        .dump_busy    (dump_busy),
        .dump_done    (dump_done),
        .err_conflict (err_conflict)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Memory contents: three preloaded words, a fixed pattern everywhere else.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_000A;
            32'h0000_0104: return 32'h0000_000B;
            32'h0000_0108: return 32'h0000_000C;
            default:       return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
        endcase
    endfunction

    // Data memory: read data appears one active (falling) edge after the read request.
    always @(negedge clk) begin
        if (bus.mem_rw == RW_READ) bus.mem_rdata <= rom(bus.mem_addr);
    end

    // Reference model: a dump is a list of word addresses consumed one read/hand-off at a time.
    bit          m_active, m_drain, m_done, m_err;
    int          m_sub;          // 0 read issued, 1 data returning, 2 offered to debug unit
    logic [31:0] m_q[$];
    logic [31:0] m_dbg;
    int          cyc = 0;
    int          start_cyc = -1, done_cyc = -1;
    bit          stall_seen;
    logic [31:0] rd_log[$];
    logic [31:0] hs_log[$];

    always @(posedge clk) begin
        bit          fwd, issue, send;
        logic [1:0]  e_rw;
        cyc++;
        if (rst) begin
            m_active = 0; m_drain = 0; m_done = 0; m_err = 0; m_sub = 0;
            m_q.delete();
            m_dbg = '0;
        end
        fwd   = (!m_active && !m_done) || m_drain;
        issue = m_active && !m_drain && (m_sub == 0);
        send  = m_active && !m_drain && (m_sub == 2);
        e_rw  = fwd ? ((bus.pipe_rw == 2'b11) ? 2'b00 : bus.pipe_rw) : (issue ? 2'b10 : 2'b00);

        chk("stall",        32'(stall),         32'(m_active));
        chk("dump_busy",    32'(dump_busy),     32'(m_active || m_done));
        chk("dump_done",    32'(dump_done),     32'(m_done));
        chk("dbg_valid",    32'(bus.dbg_valid), 32'(send));
        chk("dbg_data",     bus.dbg_data,       m_dbg);
        chk("err_conflict", 32'(err_conflict),  32'(m_err));
        chk("mem_rw",       32'(bus.mem_rw),    32'(e_rw));
        if (fwd) begin
            chk("fwd_addr",  bus.mem_addr,        bus.pipe_addr);
            chk("fwd_wdata", bus.mem_wdata,       bus.pipe_wdata);
            chk("fwd_len",   32'(bus.mem_len),    32'(bus.pipe_len));
        end
        if (issue) begin
            chk("rd_addr", bus.mem_addr,     m_q[0]);
            chk("rd_len",  32'(bus.mem_len), 32'(0));
        end

        if (bus.mem_rw == RW_READ) rd_log.push_back(bus.mem_addr);
        if (bus.dbg_valid && bus.dbg_ready) hs_log.push_back(bus.dbg_data);
        if (dump_done) done_cyc = cyc;
        if (stall) stall_seen = 1;

        if (!rst) begin
            if (!m_active && !m_done) begin
                if (bus.dump_start) begin
                    start_cyc = cyc;
                    if (bus.dump_count != '0) begin
                        for (int i = 0; i < int'(bus.dump_count); i++)
                            m_q.push_back(bus.dump_base + 32'(i) * 32'(ADDR_STEP));
                        m_active = 1; m_drain = 1; m_sub = 0;
                    end else begin
                        m_done = 1;
                    end
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (m_drain) begin
                m_drain = 0;
            end else begin
                if (bus.pipe_rw != 2'b00) m_err = 1;
                if (m_sub == 0) m_sub = 1;
                else if (m_sub == 1) begin
                    m_dbg = rom(m_q[0]);
                    m_sub = 2;
                end else if (bus.dbg_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_active = 0; m_done = 1;
                    end else begin
                        m_sub = 0;
                    end
                end
            end
        end
    end

    task automatic step_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_dump(input logic [31:0] base, input logic [CNT_W-1:0] count);
        bus.dump_start = 1'b1;
        bus.dump_base  = base;
        bus.dump_count = count;
        step_n(1);
        bus.dump_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (dump_busy && n < budget) begin
            step_n(1);
            n++;
        end
        chk("idle_timeout", 32'(dump_busy), 32'(0));
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.dbg_valid && n < budget) begin
            step_n(1);
            n++;
        end
        chk("valid_timeout", 32'(bus.dbg_valid), 32'(1));
    endtask

    function automatic logic [31:0] q_at(input int i, input bit use_hs);
        if (use_hs) return (i < hs_log.size()) ? hs_log[i] : 32'hBAD0_0000;
        return (i < rd_log.size()) ? rd_log[i] : 32'hBAD0_0000;
    endfunction

    initial begin
        logic [31:0] exp_rd[3];
        rst = 1'b1;
        bus.pipe_rw = 2'b00; bus.pipe_addr = '0; bus.pipe_wdata = '0; bus.pipe_len = 2'b00;
        bus.dump_start = 1'b0; bus.dump_base = '0; bus.dump_count = '0;
        bus.dbg_ready = 1'b1;
        step_n(2);
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_busy",  32'(dump_busy), 32'(0));
        chk("rst_valid", 32'(bus.dbg_valid), 32'(0));
        chk("rst_err",   32'(err_conflict), 32'(0));
        rst = 1'b0;
        step_n(1);

        // Pipeline store passes straight through while idle.
        bus.pipe_rw = 2'b01; bus.pipe_addr = 32'h10; bus.pipe_wdata = 32'hDEADBEEF;
        #1;
        chk("pass_rw",    32'(bus.mem_rw), 32'h1);
        chk("pass_addr",  bus.mem_addr, 32'h10);
        chk("pass_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("pass_stall", 32'(stall), 32'(0));
        step_n(1);
        bus.pipe_rw = 2'b00;

        // Three-word dump at full throughput.
        rd_log.delete(); hs_log.delete(); done_cyc = -1;
        start_dump(32'h100, 3);
        wait_idle(50);
        exp_rd[0] = 32'h100; exp_rd[1] = 32'h104; exp_rd[2] = 32'h108;
        chk("d3_reads", 32'(rd_log.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            chk("d3_rd_addr", q_at(i, 0), exp_rd[i]);
            chk("d3_data",    q_at(i, 1), 32'hA + 32'(i));
        end
        chk("d3_latency", 32'(done_cyc - start_cyc), 32'(11));

        // Zero-length dump: done next cycle, no stall, no memory traffic.
        rd_log.delete(); stall_seen = 0; done_cyc = -1;
        start_dump(32'h200, 0);
        step_n(3);
        chk("d0_latency", 32'(done_cyc - start_cyc), 32'(1));
        chk("d0_stall",   32'(stall_seen), 32'(0));
        chk("d0_reads",   32'(rd_log.size()), 32'(0));

        // Address wrap past the top of memory.
        rd_log.delete();
        start_dump(32'hFFFF_FFFC, 2);
        wait_idle(50);
        chk("wrap_rd0", q_at(0, 0), 32'hFFFF_FFFC);
        chk("wrap_rd1", q_at(1, 0), 32'h0000_0000);

        // Debug unit back-pressure during the first hand-off.
        rd_log.delete(); hs_log.delete();
        bus.dbg_ready = 1'b0;
        start_dump(32'h300, 2);
        wait_valid(20);
        step_n(5);
        chk("bp_reads_held", 32'(rd_log.size()), 32'(1));
        chk("bp_no_hs",      32'(hs_log.size()), 32'(0));
        bus.dbg_ready = 1'b1;
        wait_idle(50);
        chk("bp_reads",  32'(rd_log.size()), 32'(2));
        chk("bp_data0",  q_at(0, 1), rom(32'h300));
        chk("bp_data1",  q_at(1, 1), rom(32'h304));

        // Reset in the middle of a dump releases the pipeline at once, with no done pulse.
        done_cyc = -1;
        start_dump(32'h100, 4);
        step_n(2);
        chk("pre_rst_stall", 32'(stall), 32'(1));
        rst = 1'b1;
        #1;
        chk("abort_stall", 32'(stall), 32'(0));
        chk("abort_busy",  32'(dump_busy), 32'(0));
        step_n(2);
        rst = 1'b0;
        step_n(5);
        chk("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

        // Pipeline read arriving during a hand-off is dropped and flagged.
        bus.dbg_ready = 1'b0;
        start_dump(32'h400, 1);
        wait_valid(20);
        bus.pipe_rw = 2'b10; bus.pipe_addr = 32'h40;
        #1;
        chk("conflict_drop", 32'(bus.mem_rw), 32'(0));
        step_n(1);
        bus.pipe_rw = 2'b00;
        chk("conflict_flag", 32'(err_conflict), 32'(1));
        bus.dbg_ready = 1'b1;
        wait_idle(20);
        step_n(2);
        chk("conflict_sticky", 32'(err_conflict), 32'(1));
        rst = 1'b1;
        step_n(1);
        rst = 1'b0;
        chk("conflict_clr", 32'(err_conflict), 32'(0));

        // Random traffic, all checked cycle by cycle against the model.
        for (int it = 0; it < 3000; it++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.pipe_rw    = 2'($urandom_range(0, 3));
            bus.pipe_addr  = $urandom;
            bus.pipe_wdata = $urandom;
            bus.pipe_len   = 2'($urandom_range(0, 3));
            bus.dump_start = !rst && ($urandom_range(0, 7) == 0);
            bus.dump_base  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                        : $urandom;
            bus.dump_count = CNT_W'($urandom_range(0, 4));
            bus.dbg_ready  = ($urandom_range(0, 3) != 0);
            step_n(1);
        end
        rst = 1'b0;
        bus.pipe_rw = 2'b00; bus.dump_start = 1'b0; bus.dbg_ready = 1'b1;
        wait_idle(50);
        step_n(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
